// File: rtl/watch_counter.sv
// watch_counter: time-of-day/calendar counter (2000..2099) with 1 Hz prescaler and checked loads.
// Optional alarm compare enabled by defining WATCH_ALARM_EN.
module watch_counter #(
  parameter int CLK_HZ = 50000000,
  parameter int PRE_W  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_time,
  input  logic [47:0] bin_time,
`ifdef WATCH_ALARM_EN
  input  logic [7:0]  alarm_hour,
  input  logic [7:0]  alarm_minute,
  input  logic [0:0]  alarm_on,
  output logic        alarm_hit,
`endif
  output logic [7:0]  year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic [47:0] time_out,
  output logic        tick_1hz,
  output logic        load_err
);
  function automatic logic [7:0] dim(input logic [7:0] y, input logic [7:0] m);
    return (m == 8'd2) ? ((y[1:0] == 2'd0) ? 8'd29 : 8'd28) :
           (m == 8'd4 || m == 8'd6 || m == 8'd9 || m == 8'd11) ? 8'd30 : 8'd31;
  endfunction
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0] yr_q, mo_q, dy_q, hr_q, mi_q, se_q;
  logic [7:0] yr_d, mo_d, dy_d, hr_d, mi_d, se_d;
  logic [7:0] n_yr, n_mo, n_dy, n_hr, n_mi, n_se;
  logic [7:0] l_yr, l_mo, l_dy, l_hr, l_mi, l_se;
  logic tick_q, tick_d, err_q, err_d;
  logic wrap, valid, load_ok, adv, c_s, c_m, c_h, c_d, c_mo;
  always_comb begin
    {l_yr, l_mo, l_dy, l_hr, l_mi, l_se} = bin_time;
    valid = l_yr <= 8'd99 && l_mo >= 8'd1 && l_mo <= 8'd12 && l_dy >= 8'd1 &&
            l_dy <= dim(l_yr, l_mo) && l_hr <= 8'd23 && l_mi <= 8'd59 && l_se <= 8'd59;
    load_ok = en_time && valid;
    wrap = pre_q == PRE_W'(CLK_HZ - 1);
    adv = wrap && !load_ok;
    pre_d = (load_ok || wrap) ? '0 : pre_q + 1'b1;
    c_s = se_q == 8'd59;
    c_m = c_s && mi_q == 8'd59;
    c_h = c_m && hr_q == 8'd23;
    c_d = c_h && dy_q == dim(yr_q, mo_q);
    c_mo = c_d && mo_q == 8'd12;
    n_se = c_s ? 8'd0 : se_q + 8'd1;
    n_mi = c_s ? (c_m ? 8'd0 : mi_q + 8'd1) : mi_q;
    n_hr = c_m ? (c_h ? 8'd0 : hr_q + 8'd1) : hr_q;
    n_dy = c_h ? (c_d ? 8'd1 : dy_q + 8'd1) : dy_q;
    n_mo = c_d ? (c_mo ? 8'd1 : mo_q + 8'd1) : mo_q;
    n_yr = c_mo ? ((yr_q == 8'd99) ? 8'd0 : yr_q + 8'd1) : yr_q;
    se_d = load_ok ? l_se : adv ? n_se : se_q;
    mi_d = load_ok ? l_mi : adv ? n_mi : mi_q;
    hr_d = load_ok ? l_hr : adv ? n_hr : hr_q;
    dy_d = load_ok ? l_dy : adv ? n_dy : dy_q;
    mo_d = load_ok ? l_mo : adv ? n_mo : mo_q;
    yr_d = load_ok ? l_yr : adv ? n_yr : yr_q;
    tick_d = adv;
    err_d = en_time && !valid;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      yr_q   <= 8'd0;
      mo_q   <= 8'd1;
      dy_q   <= 8'd1;
      hr_q   <= 8'd0;
      mi_q   <= 8'd0;
      se_q   <= 8'd0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      yr_q   <= yr_d;
      mo_q   <= mo_d;
      dy_q   <= dy_d;
      hr_q   <= hr_d;
      mi_q   <= mi_d;
      se_q   <= se_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end
`ifdef WATCH_ALARM_EN
  logic alarm_q, alarm_d;
  // Compare against the advanced time so the hit lands on the tick that reaches hh:mm:00.
  always_comb alarm_d = adv && alarm_on[0] && n_hr == alarm_hour && n_mi == alarm_minute && n_se == 8'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alarm_q <= 1'b0;
    else alarm_q <= alarm_d;
  end
  assign alarm_hit = alarm_q;
`endif
  assign year     = yr_q;
  assign month    = mo_q;
  assign day      = dy_q;
  assign hour     = hr_q;
  assign minute   = mi_q;
  assign second   = se_q;
  assign time_out = {yr_q, mo_q, dy_q, hr_q, mi_q, se_q};
  assign tick_1hz = tick_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_watch_counter.sv
// tb_watch_counter: directed self-checking bench for watch_counter with CLK_HZ=10.
module tb_watch_counter;
  logic clk = 1'b0, rst = 1'b0, en_time = 1'b0;
  logic [47:0] bin_time = '0;
  logic [7:0] year, month, day, hour, minute, second;
  logic [47:0] time_out;
  logic tick_1hz, load_err;
  int checks = 0, errors = 0, n = 0, ticks = 0;
`ifdef WATCH_ALARM_EN
  logic [7:0] alarm_hour = 8'd8, alarm_minute = 8'd10;
  logic [0:0] alarm_on = 1'b1;
  logic alarm_hit;
`endif
  watch_counter #(.CLK_HZ(10), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .en_time(en_time), .bin_time(bin_time),
`ifdef WATCH_ALARM_EN
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_on(alarm_on), .alarm_hit(alarm_hit),
`endif
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
    .time_out(time_out), .tick_1hz(tick_1hz), .load_err(load_err)
  );
  always #5 clk = ~clk;
  function automatic logic [47:0] pk(int y, int mo, int d, int h, int mi, int s);
    return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [47:0] v);
    en_time = 1'b1;
    bin_time = v;
    step();
    en_time = 1'b0;
  endtask
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick_1hz && cnt < 30);
  endtask
  initial begin
    repeat (2) step();
    chk("reset_time", time_out, pk(0, 1, 1, 0, 0, 0));
    chk("reset_tick", tick_1hz, 0);
    chk("reset_err", load_err, 0);
    rst = 1'b1;
    wait_tick(n);
    chk("first_tick_latency", n, 10);
    chk("first_tick_second", second, 1);
    load(pk(24, 2, 28, 23, 59, 59));
    chk("load_leap_val", time_out, pk(24, 2, 28, 23, 59, 59));
    chk("load_no_tick", tick_1hz, 0);
    wait_tick(n);
    chk("leap_tick_latency", n, 10);
    chk("leap_feb29", time_out, pk(24, 2, 29, 0, 0, 0));
    load(pk(24, 2, 29, 23, 59, 59));
    wait_tick(n);
    chk("leap_mar1", time_out, pk(24, 3, 1, 0, 0, 0));
    load(pk(23, 2, 28, 23, 59, 59));
    wait_tick(n);
    chk("nonleap_mar1", time_out, pk(23, 3, 1, 0, 0, 0));
    load(pk(99, 12, 31, 23, 59, 59));
    wait_tick(n);
    chk("century_wrap", time_out, 48'h00_01_01_00_00_00);
    chk("century_year", year, 0);
    load(pk(10, 13, 1, 0, 0, 0));
    chk("bad_month_err", load_err, 1);
    chk("bad_month_time", time_out, 48'h00_01_01_00_00_00);
    load(pk(23, 2, 29, 0, 0, 0));
    chk("bad_feb29_err", load_err, 1);
    load(pk(10, 5, 5, 5, 60, 0));
    chk("bad_minute_err", load_err, 1);
    chk("bad_minute_time", time_out, 48'h00_01_01_00_00_00);
    step();
    chk("err_one_cycle", load_err, 0);
    wait_tick(n);
    chk("tick_after_bad_loads", n, 6);
    chk("second_after_bad_loads", time_out, pk(0, 1, 1, 0, 0, 1));
    repeat (9) step();
    load(pk(5, 6, 7, 8, 9, 10));
    chk("wrap_load_val", time_out, pk(5, 6, 7, 8, 9, 10));
    chk("wrap_load_no_tick", tick_1hz, 0);
    wait_tick(n);
    chk("wrap_load_next_tick", n, 10);
    chk("wrap_load_second", second, 11);
    en_time = 1'b1;
    bin_time = pk(1, 1, 31, 1, 1, 1);
    ticks = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (tick_1hz) ticks++;
    end
    en_time = 1'b0;
    chk("held_load_no_ticks", ticks, 0);
    chk("held_load_val", time_out, pk(1, 1, 31, 1, 1, 1));
`ifdef WATCH_ALARM_EN
    load(pk(5, 6, 7, 8, 9, 58));
    wait_tick(n);
    chk("alarm_tick1", alarm_hit, 0);
    wait_tick(n);
    chk("alarm_tick2_time", time_out, pk(5, 6, 7, 8, 10, 0));
    chk("alarm_tick2_hit", alarm_hit, 1);
    step();
    chk("alarm_one_cycle", alarm_hit, 0);
    alarm_on = 1'b0;
    load(pk(5, 6, 7, 8, 9, 59));
    wait_tick(n);
    chk("alarm_off", alarm_hit, 0);
    alarm_on = 1'b1;
`endif
    en_time = 1'b1;
    bin_time = pk(50, 7, 7, 7, 7, 7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_reset_time", time_out, pk(0, 1, 1, 0, 0, 0));
    step();
    chk("reset_drops_load", time_out, pk(0, 1, 1, 0, 0, 0));
    en_time = 1'b0;
    rst = 1'b1;
    wait_tick(n);
    chk("post_reset_tick", n, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
